eth_phy_10g_rx_sync: RTL and testbench
======================================

Name: eth_phy_10g_rx_sync

Overview:
Receive-side 10GBASE-R block synchronisation and BER monitor. It sits between the SERDES RX interface and the RX descrambler/decoder path. It watches the 2-bit sync header of each 66b block and hunts for block lock by requesting bit slips from the SERDES gearbox. Once locked, it monitors the header error rate in the manner of IEEE 802.3 Clause 49.

Parameters:
HDR_WIDTH, 2, sync header width; must be 2, elaboration $error otherwise
BITSLIP_HIGH_CYCLES, 1, cycles serdes_rx_bitslip is held high per slip (>=1)
BITSLIP_LOW_CYCLES, 8, settle cycles after a slip during which headers are ignored (>=1)
COUNT_125US, 19531, clk cycles per BER window (125 us at 156.25 MHz)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
serdes_rx_hdr  in  HDR_WIDTH  sync header of current block
serdes_rx_hdr_valid  in  1  header qualifier (gearbox gap when 0)
serdes_rx_bitslip  out  1  slip request to SERDES gearbox
rx_block_lock  out  1  block lock achieved
rx_high_ber  out  1  high bit-error-rate indication

Behaviour:
- Reset: clock is clk. rst is asynchronous and active-low. While rst=0, all outputs are 0, the FSM is in HUNT, and all counters are 0. Outputs are registered.
- Header classification:
  - 2'b01 (data) and 2'b10 (ctrl) are valid.
  - 2'b00 and 2'b11 are invalid.
  - Headers are sampled only when serdes_rx_hdr_valid=1; all other cycles are ignored by both the FSM and the BER monitor (the timer still runs).
- Latency: a qualifying header affects the outputs on the next clk edge (1 cycle).
- FSM states and transitions:
  - HUNT (rx_block_lock=0):
    - Valid header: sh_cnt++.
    - 64th consecutive valid header: rx_block_lock<=1, clear counters, go to LOCKED.
    - Any invalid header: clear sh_cnt, go to SLIP.
  - LOCKED (rx_block_lock=1):
    - Every header: sh_cnt++. Invalid header: sh_inv_cnt++.
    - If sh_inv_cnt reaches 16 within the 64-header window: rx_block_lock<=0, go to SLIP.
    - When the 64th header of a window arrives with sh_inv_cnt<16: clear both counters, stay in LOCKED.
    - If the 64th header is also the 16th invalid: the loss of lock wins.
  - SLIP:
    - serdes_rx_bitslip=1 for BITSLIP_HIGH_CYCLES cycles, then 0 for BITSLIP_LOW_CYCLES cycles. Headers are ignored throughout.
    - Then go to HUNT with counters cleared.
- Counter widths: sh_cnt is 6 bits and wraps 63->0 only via an explicit clear. sh_inv_cnt is 5 bits.
- BER monitor (sub-module):
  - Active only while rx_block_lock=1.
  - Window timer counts 0..COUNT_125US-1 and restarts.
  - Each qualifying invalid header increments ber_cnt, which saturates at 16.
  - When ber_cnt reaches 16: rx_high_ber<=1 on the next edge.
  - At window expiry:
    - If ber_cnt<16: rx_high_ber<=0.
    - ber_cnt<=0 in all cases.
  - An invalid header on the expiry cycle counts toward the closing window.
  - When rx_block_lock=0: timer, ber_cnt and rx_high_ber are held at 0.
- Loss of lock mid-window: the BER state clears on the cycle after rx_block_lock falls.
- rst asserted mid-operation: outputs go to 0 immediately, without waiting for clk.

Decomposition:
- Shared package eth_phy_10g_pkg holds:
  - SYNC_DATA=2'b01 and SYNC_CTRL=2'b10
  - SH_LOCK_CNT=64, SH_INVALID_LIMIT=16, BER_LIMIT=16
  - FSM state encodings HUNT/LOCKED/SLIP
- Sub-module eth_phy_10g_rx_ber_mon contains the window timer, ber_cnt and rx_high_ber. Its inputs are clk, rst, hdr_valid, hdr_invalid and block_lock.
- The top-level module holds the lock FSM and the slip timer.

Test Plan:
- Release rst, then drive 64 consecutive 2'b01 headers with valid=1 -> rx_block_lock=1 one cycle after the 64th header; serdes_rx_bitslip never asserts.
- In HUNT, drive hdr 2'b00 as the 10th header -> bitslip high for exactly 1 cycle, then low 8 cycles with headers ignored; lock needs 64 further valid headers.
- While LOCKED: 15 invalid (2'b11) headers within one 64-header window -> lock held. 16 invalid in the next window -> rx_block_lock=0 and one bitslip pulse.
- With COUNT_125US=200, while LOCKED: 16 invalid headers spread across 4 64-header windows (4 per window) inside one BER window -> rx_high_ber=1 and lock held. Next BER window with 0 invalid -> rx_high_ber=0 on its expiry.
- Invalid headers driven with hdr_valid=0, interleaved with 64 valid headers -> lock achieved with no slip and no BER count.
- While LOCKED with rx_high_ber=1, drive rst=0 between clk edges -> all outputs 0 immediately. After release, the FSM is in HUNT.

Source files
------------

// File: rtl/eth_phy_10g_pkg.sv
// Shared constants for the 10GBASE-R receive block-sync path: sync header codes,
// lock/BER thresholds and the lock FSM state encodings.
package eth_phy_10g_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int SH_LOCK_CNT      = 64;
  localparam int SH_INVALID_LIMIT = 16;
  localparam int BER_LIMIT        = 16;

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] LOCKED = 2'd1;
  localparam logic [1:0] SLIP   = 2'd2;

  // Only the two transition codes mark a legal 66b block boundary.
  function automatic logic sync_hdr_ok(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_ber_mon.sv
// Header BER monitor: counts invalid sync headers per 125 us window and flags high BER.
// Held cleared whenever block lock is down; high_ber updates on the edge that samples the header.
module eth_phy_10g_rx_ber_mon
  import eth_phy_10g_pkg::*;
#(
  parameter int COUNT_125US = 19531
) (
  input  logic clk,
  input  logic rst,
  input  logic hdr_valid,
  input  logic hdr_invalid,
  input  logic block_lock,
  output logic rx_high_ber
);

  localparam int TW = (COUNT_125US > 1) ? $clog2(COUNT_125US) : 1;
  localparam int BW = $clog2(BER_LIMIT + 1);

  logic [TW-1:0] r_timer;
  logic [BW-1:0] r_ber_cnt;
  logic          r_high_ber;
  logic          w_expire;
  logic          w_ber_hit;
  logic [BW-1:0] w_ber_next;

  assign w_expire = (r_timer == TW'(COUNT_125US - 1));

  always_comb begin
    w_ber_next = r_ber_cnt;
    if (hdr_valid && hdr_invalid && (r_ber_cnt != BW'(BER_LIMIT))) begin
      w_ber_next = r_ber_cnt + BW'(1);
    end
  end

  assign w_ber_hit = (w_ber_next == BW'(BER_LIMIT));

  // A header on the expiry cycle still belongs to the window that is closing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer    <= '0;
      r_ber_cnt  <= '0;
      r_high_ber <= 1'b0;
    end else if (!block_lock) begin
      r_timer    <= '0;
      r_ber_cnt  <= '0;
      r_high_ber <= 1'b0;
    end else if (w_expire) begin
      r_timer    <= '0;
      r_ber_cnt  <= '0;
      r_high_ber <= w_ber_hit;
    end else begin
      r_timer   <= r_timer + TW'(1);
      r_ber_cnt <= w_ber_next;
      if (w_ber_hit) begin
        r_high_ber <= 1'b1;
      end
    end
  end

  assign rx_high_ber = r_high_ber;

endmodule

// File: rtl/eth_phy_10g_rx_sync.sv
// 10GBASE-R RX block lock FSM with gearbox bit-slip control and BER monitor.
// All outputs registered; a qualifying header is reflected one clk edge later.
module eth_phy_10g_rx_sync
  import eth_phy_10g_pkg::*;
#(
  parameter int HDR_WIDTH           = 2,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int COUNT_125US         = 19531
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
  input  logic                 serdes_rx_hdr_valid,
  output logic                 serdes_rx_bitslip,
  output logic                 rx_block_lock,
  output logic                 rx_high_ber
);

  if (HDR_WIDTH != 2) begin : g_hdr_width_chk
    $error("eth_phy_10g_rx_sync: HDR_WIDTH must be 2");
  end
  if (BITSLIP_HIGH_CYCLES < 1 || BITSLIP_LOW_CYCLES < 1) begin : g_slip_chk
    $error("eth_phy_10g_rx_sync: bitslip cycle counts must be >= 1");
  end

  localparam int SLIP_TOTAL = BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES;
  localparam int SLIP_W     = $clog2(SLIP_TOTAL + 1);

  logic [1:0]        r_state;
  logic [5:0]        r_sh_cnt;
  logic [4:0]        r_sh_inv_cnt;
  logic [SLIP_W-1:0] r_slip_cnt;
  logic              r_bitslip;
  logic              r_block_lock;
  logic              w_hdr_ok;
  logic              w_hdr_inv;
  logic              w_win_last;
  logic              w_inv_last;

  assign w_hdr_ok   = sync_hdr_ok(serdes_rx_hdr);
  assign w_hdr_inv  = ~w_hdr_ok;
  assign w_win_last = (r_sh_cnt == 6'(SH_LOCK_CNT - 1));
  assign w_inv_last = (r_sh_inv_cnt == 5'(SH_INVALID_LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= HUNT;
      r_sh_cnt     <= '0;
      r_sh_inv_cnt <= '0;
      r_slip_cnt   <= '0;
      r_bitslip    <= 1'b0;
      r_block_lock <= 1'b0;
    end else begin
      case (r_state)
        HUNT: begin
          if (serdes_rx_hdr_valid) begin
            if (w_hdr_ok) begin
              if (w_win_last) begin
                r_block_lock <= 1'b1;
                r_sh_cnt     <= '0;
                r_sh_inv_cnt <= '0;
                r_state      <= LOCKED;
              end else begin
                r_sh_cnt <= r_sh_cnt + 6'd1;
              end
            end else begin
              r_sh_cnt   <= '0;
              r_slip_cnt <= '0;
              r_bitslip  <= 1'b1;
              r_state    <= SLIP;
            end
          end
        end
        LOCKED: begin
          if (serdes_rx_hdr_valid) begin
            // Loss of lock takes priority over closing the 64-header window.
            if (w_hdr_inv && w_inv_last) begin
              r_block_lock <= 1'b0;
              r_sh_cnt     <= '0;
              r_sh_inv_cnt <= '0;
              r_slip_cnt   <= '0;
              r_bitslip    <= 1'b1;
              r_state      <= SLIP;
            end else if (w_win_last) begin
              r_sh_cnt     <= '0;
              r_sh_inv_cnt <= '0;
            end else begin
              r_sh_cnt <= r_sh_cnt + 6'd1;
              if (w_hdr_inv) begin
                r_sh_inv_cnt <= r_sh_inv_cnt + 5'd1;
              end
            end
          end
        end
        SLIP: begin
          if (r_slip_cnt == SLIP_W'(BITSLIP_HIGH_CYCLES - 1)) begin
            r_bitslip <= 1'b0;
          end
          if (r_slip_cnt == SLIP_W'(SLIP_TOTAL - 1)) begin
            r_state      <= HUNT;
            r_sh_cnt     <= '0;
            r_sh_inv_cnt <= '0;
            r_slip_cnt   <= '0;
          end else begin
            r_slip_cnt <= r_slip_cnt + SLIP_W'(1);
          end
        end
        default: begin
          r_state   <= HUNT;
          r_bitslip <= 1'b0;
        end
      endcase
    end
  end

  eth_phy_10g_rx_ber_mon #(
    .COUNT_125US(COUNT_125US)
  ) u_ber_mon (
    .clk        (clk),
    .rst        (rst),
    .hdr_valid  (serdes_rx_hdr_valid),
    .hdr_invalid(w_hdr_inv),
    .block_lock (r_block_lock),
    .rx_high_ber(rx_high_ber)
  );

  assign serdes_rx_bitslip = r_bitslip;
  assign rx_block_lock     = r_block_lock;

endmodule

// File: tb/tb_eth_phy_10g_rx_sync.sv
// Directed plus randomized bench for eth_phy_10g_rx_sync, checked every cycle
// against a counter-based reference model of the block-lock and BER rules.
module tb_eth_phy_10g_rx_sync;

  localparam int HIGH = 1;
  localparam int LOW  = 8;
  localparam int CNT  = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] hdr;
  logic       vld;
  logic       serdes_rx_bitslip;
  logic       rx_block_lock;
  logic       rx_high_ber;

  int checks = 0;
  int errors = 0;

  bit m_lock, m_bitslip, m_high;
  int m_slip_left, m_run, m_win, m_bad, m_timer, m_ber;

  eth_phy_10g_rx_sync #(
    .HDR_WIDTH          (2),
    .BITSLIP_HIGH_CYCLES(HIGH),
    .BITSLIP_LOW_CYCLES (LOW),
    .COUNT_125US        (CNT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .serdes_rx_hdr      (hdr),
    .serdes_rx_hdr_valid(vld),
    .serdes_rx_bitslip  (serdes_rx_bitslip),
    .rx_block_lock      (rx_block_lock),
    .rx_high_ber        (rx_high_ber)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_bitslip = 0; m_high = 0;
    m_slip_left = 0; m_run = 0; m_win = 0; m_bad = 0; m_timer = 0; m_ber = 0;
  endtask

  task automatic enter_slip();
    m_slip_left = HIGH + LOW;
    m_bitslip   = 1;
  endtask

  // One clock edge of the reference: BER rules see the lock state before the edge.
  task automatic model_edge(input logic [1:0] h, input logic v);
    bit good;
    int nb;
    good = (h == 2'b01) || (h == 2'b10);
    if (!m_lock) begin
      m_timer = 0; m_ber = 0; m_high = 0;
    end else begin
      nb = m_ber + ((v && !good) ? 1 : 0);
      if (nb > 16) nb = 16;
      if (m_timer == CNT - 1) begin
        m_high  = (nb >= 16);
        m_ber   = 0;
        m_timer = 0;
      end else begin
        if (nb >= 16) m_high = 1;
        m_ber = nb;
        m_timer++;
      end
    end
    if (m_slip_left > 0) begin
      m_slip_left--;
      m_bitslip = (m_slip_left > LOW);
      if (m_slip_left == 0) m_run = 0;
    end else if (!m_lock) begin
      if (v) begin
        if (good) begin
          m_run++;
          if (m_run == 64) begin
            m_lock = 1; m_run = 0; m_win = 0; m_bad = 0;
          end
        end else begin
          m_run = 0;
          enter_slip();
        end
      end
    end else if (v) begin
      m_win++;
      if (!good) m_bad++;
      if (m_bad == 16) begin
        m_lock = 0; m_win = 0; m_bad = 0;
        enter_slip();
      end else if (m_win == 64) begin
        m_win = 0; m_bad = 0;
      end
    end
  endtask

  task automatic step(input logic [1:0] h, input logic v);
    hdr = h;
    vld = v;
    @(posedge clk);
    model_edge(h, v);
    #1;
    chk("bitslip", serdes_rx_bitslip, m_bitslip);
    chk("block_lock", rx_block_lock, m_lock);
    chk("high_ber", rx_high_ber, m_high);
  endtask

  // Asserts rst between edges and checks outputs drop before any clock edge.
  task automatic do_reset();
    hdr = 2'b00;
    vld = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_bitslip", serdes_rx_bitslip, 1'b0);
    chk("rst_lock", rx_block_lock, 1'b0);
    chk("rst_high_ber", rx_high_ber, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  initial begin
    int rates[6];
    int rate;
    logic [1:0] h;
    logic v;
    rates = '{4, 10, 12, 50, 9, 6};
    rst = 1'b0;
    hdr = 2'b00;
    vld = 1'b0;
    model_reset();
    do_reset();

    // Acquire lock from 64 data headers.
    for (int i = 0; i < 63; i++) step(2'b01, 1'b1);
    chk("lock_before_64th", rx_block_lock, 1'b0);
    step(2'b01, 1'b1);
    chk("lock_at_64th", rx_block_lock, 1'b1);

    // 15 invalid in one window keeps lock; 16 in the next drops it.
    for (int i = 0; i < 64; i++) step((i % 4 == 1 && i < 60) ? 2'b11 : 2'b10, 1'b1);
    chk("lock_held_15_inv", rx_block_lock, 1'b1);
    for (int i = 0; i < 16; i++) step(2'b11, 1'b1);
    chk("lock_lost_16_inv", rx_block_lock, 1'b0);
    chk("slip_pulse_on_loss", serdes_rx_bitslip, 1'b1);
    for (int i = 0; i < HIGH + LOW; i++) step(2'($urandom_range(0, 3)), 1'b1);
    chk("slip_low_after_pulse", serdes_rx_bitslip, 1'b0);

    // Invalid 10th header in HUNT triggers a slip; lock needs 64 fresh headers.
    for (int i = 0; i < 9; i++) step(2'b01, 1'b1);
    step(2'b00, 1'b1);
    chk("hunt_slip_pulse", serdes_rx_bitslip, 1'b1);
    step(2'b11, 1'b1);
    chk("hunt_slip_one_cycle", serdes_rx_bitslip, 1'b0);
    for (int i = 1; i < HIGH + LOW; i++) step(2'b00, 1'b1);
    for (int i = 0; i < 63; i++) step(2'b10, 1'b1);
    chk("relock_before_64th", rx_block_lock, 1'b0);
    step(2'b10, 1'b1);
    chk("relock_at_64th", rx_block_lock, 1'b1);

    // 4 invalid per header window, 16 inside one BER window.
    for (int p = 0; p < 256; p++) begin
      step((p % 64 < 4) ? 2'b11 : 2'b01, 1'b1);
      if (p == 194) chk("ber_low_at_15", rx_high_ber, 1'b0);
      if (p == 195) chk("ber_high_at_16", rx_high_ber, 1'b1);
    end
    chk("ber_lock_held", rx_block_lock, 1'b1);
    for (int p = 256; p < 400; p++) begin
      step(2'b01, 1'b1);
      if (p == 398) chk("ber_hold_until_expiry", rx_high_ber, 1'b1);
      if (p == 399) chk("ber_clear_on_expiry", rx_high_ber, 1'b0);
    end

    // Unqualified invalid headers are ignored by FSM and BER counter.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      step(2'b11, 1'b0);
      step(2'b01, 1'b1);
    end
    chk("gap_lock", rx_block_lock, 1'b1);
    for (int i = 0; i < 220; i++) step((i % 2 == 0) ? 2'b00 : 2'b10, i % 2 == 1);
    chk("gap_no_ber", rx_high_ber, 1'b0);
    chk("gap_lock_held", rx_block_lock, 1'b1);

    // Drive to high BER, then reset asynchronously.
    for (int i = 0; i < 400 && !rx_high_ber; i++) step((i % 64 < 12) ? 2'b11 : 2'b01, 1'b1);
    chk("ber_high_before_rst", rx_high_ber, 1'b1);
    do_reset();
    for (int i = 0; i < 63; i++) step(2'b01, 1'b1);
    chk("post_rst_hunt", rx_block_lock, 1'b0);
    step(2'b01, 1'b1);
    chk("post_rst_lock", rx_block_lock, 1'b1);

    // Randomized traffic at varied error rates and header gaps.
    for (int r = 0; r < 12; r++) begin
      rate = rates[r % 6];
      for (int i = 0; i < 250; i++) begin
        v = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, rate - 1) == 0) h = $urandom_range(0, 1) ? 2'b00 : 2'b11;
        else h = $urandom_range(0, 1) ? 2'b01 : 2'b10;
        step(h, v);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
